// File: rtl/apb_master_bridge_if.sv
// Bundles the core load/store request port and the APB bus of the bridge.
// The master modport is the bridge's view; the slave modport is the core/peripheral side.
interface apb_master_bridge_if #(
  parameter int NUM_SLV = 4
);
  logic                   transfer;
  logic                   write;
  logic [31:0]            addr;
  logic [31:0]            wdata;
  logic [31:0]            rdata;
  logic                   ready;
  logic                   err;
  logic [31:0]            PADDR;
  logic                   PWRITE;
  logic                   PENABLE;
  logic [31:0]            PWDATA;
  logic [NUM_SLV-1:0]     PSEL;
  logic [NUM_SLV*32-1:0]  PRDATA;
  logic [NUM_SLV-1:0]     PREADY;

  modport master (
    input  transfer, write, addr, wdata, PRDATA, PREADY,
    output rdata, ready, err, PADDR, PWRITE, PENABLE, PWDATA, PSEL
  );

  modport slave (
    output transfer, write, addr, wdata, PRDATA, PREADY,
    input  rdata, ready, err, PADDR, PWRITE, PENABLE, PWDATA, PSEL
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB initiator: decodes the core request to one PSEL, runs SETUP/ACCESS, returns rdata with a one-cycle ready.
// Latency >= 3 cycles (2 for unmapped); waits on the selected PREADY, aborting with err after TIMEOUT ACCESS cycles.
module apb_master_bridge #(
  parameter int          NUM_SLV     = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          REGION_BITS = 12,
  parameter int          TIMEOUT     = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  apb_master_bridge_if.master  bus
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [31:0]          paddr_q, paddr_d;
  logic                 pwrite_q, pwrite_d;
  logic                 penable_q, penable_d;
  logic [31:0]          pwdata_q, pwdata_d;
  logic [NUM_SLV-1:0]   psel_q, psel_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 ready_q, ready_d;
  logic                 err_q, err_d;

  logic [32:0]          offset;
  logic [31:0]          region;
  logic                 mapped;
  logic                 sel_ready;
  logic [31:0]          sel_rdata;

  // 33-bit subtraction so addresses below the window show up as a borrow.
  assign offset    = {1'b0, bus.addr} - {1'b0, BASE_ADDR};
  assign region    = offset[31:0] >> REGION_BITS;
  assign mapped    = !offset[32] && (region < 32'(NUM_SLV));
  assign sel_ready = |(bus.PREADY & psel_q);

  // PSEL stays one-hot through ACCESS, so it doubles as the read-lane select.
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (psel_q[i]) begin
        sel_rdata = sel_rdata | bus.PRDATA[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    penable_d = penable_q;
    pwdata_d  = pwdata_q;
    psel_d    = psel_q;
    rdata_d   = rdata_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.transfer) begin
          if (mapped) begin
            paddr_d   = bus.addr;
            pwrite_d  = bus.write;
            if (bus.write) begin
              pwdata_d = bus.wdata;
            end
            psel_d    = NUM_SLV'(1) << region[TW-1:0] & {NUM_SLV{1'b1}};
            penable_d = 1'b0;
            state_d   = SETUP;
          end else begin
            state_d = ERR;
          end
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        timer_d   = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (sel_ready) begin
          psel_d    = '0;
          penable_d = 1'b0;
          ready_d   = 1'b1;
          err_d     = 1'b0;
          rdata_d   = pwrite_q ? 32'h0 : sel_rdata;
          state_d   = IDLE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          psel_d    = '0;
          penable_d = 1'b0;
          ready_d   = 1'b1;
          err_d     = 1'b1;
          rdata_d   = 32'h0;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ERR: begin
        ready_d = 1'b1;
        err_d   = 1'b1;
        rdata_d = 32'h0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      penable_q <= 1'b0;
      pwdata_q  <= '0;
      psel_q    <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      penable_q <= penable_d;
      pwdata_q  <= pwdata_d;
      psel_q    <= psel_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end

  assign bus.PADDR   = paddr_q;
  assign bus.PWRITE  = pwrite_q;
  assign bus.PENABLE = penable_q;
  assign bus.PWDATA  = pwdata_q;
  assign bus.PSEL    = psel_q;
  assign bus.rdata   = rdata_q;
  assign bus.ready   = ready_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: expected strobes are queued at launch and matched when ready appears.
module tb_apb_master_bridge;

  logic PCLK;
  logic PRESET;

  apb_master_bridge_if #(.NUM_SLV(4)) bus ();

  apb_master_bridge #(
    .NUM_SLV    (4),
    .BASE_ADDR  (32'h1000_0000),
    .REGION_BITS(12),
    .TIMEOUT    (16)
  ) dut (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .bus   (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock; outputs are sampled 1ns after the rising edge.
  task automatic step();
    exp_t e;
    logic want;
    @(posedge PCLK);
    #1;
    cyc++;
    want = (sb.size() > 0) && (sb[0].cyc == cyc);
    chk("ready_strobe", 32'(bus.ready), 32'(want));
    if (bus.ready && sb.size() > 0) begin
      e = sb.pop_front();
      chk("rdata", bus.rdata, e.rdata);
      chk("err", 32'(bus.err), 32'(e.err));
      bus.transfer = 1'b0;
    end else if (!bus.ready) begin
      chk("err_idle", 32'(bus.err), 32'h0);
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        void'(sb.pop_front());
      end
    end
  endtask

  task automatic launch(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input bit push, input logic [31:0] exp_rd, input logic exp_err,
                        input int lat);
    exp_t e;
    bus.transfer = 1'b1;
    bus.write    = wr;
    bus.addr     = a;
    bus.wdata    = wd;
    if (push) begin
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.cyc   = cyc + lat;
      sb.push_back(e);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_psel"}, 32'(bus.PSEL), 32'h0);
    chk({tag, "_penable"}, 32'(bus.PENABLE), 32'h0);
    chk({tag, "_paddr"}, bus.PADDR, 32'h0);
    chk({tag, "_pwdata"}, bus.PWDATA, 32'h0);
    chk({tag, "_pwrite"}, 32'(bus.PWRITE), 32'h0);
    chk({tag, "_rdata"}, bus.rdata, 32'h0);
    chk({tag, "_ready"}, 32'(bus.ready), 32'h0);
  endtask

  logic [31:0] unmapped_addrs [3];

  initial begin
    unmapped_addrs[0] = 32'h2000_0000;
    unmapped_addrs[1] = 32'h1000_4000;
    unmapped_addrs[2] = 32'h0FFF_FFFC;

    PRESET       = 1'b1;
    bus.transfer = 1'b0;
    bus.write    = 1'b0;
    bus.addr     = '0;
    bus.wdata    = '0;
    bus.PRDATA   = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
    bus.PREADY   = '0;

    step();
    step();
    chk_zero_outputs("reset");
    PRESET = 1'b0;
    step();

    // Write slave1, registered PREADY: ready at cycle 4.
    launch(1'b1, 32'h1000_1004, 32'h0000_1234, 1'b1, 32'h0, 1'b0, 4);
    step();
    chk("t1_psel_setup", 32'(bus.PSEL), 32'h2);
    chk("t1_penable_setup", 32'(bus.PENABLE), 32'h0);
    chk("t1_paddr", bus.PADDR, 32'h1000_1004);
    chk("t1_pwrite", 32'(bus.PWRITE), 32'h1);
    chk("t1_pwdata", bus.PWDATA, 32'h0000_1234);
    step();
    chk("t1_penable_acc1", 32'(bus.PENABLE), 32'h1);
    step();
    chk("t1_penable_acc2", 32'(bus.PENABLE), 32'h1);
    bus.PREADY = 4'b0010;
    step();
    bus.PREADY = 4'b0000;
    chk("t1_psel_done", 32'(bus.PSEL), 32'h0);
    chk("t1_penable_done", 32'(bus.PENABLE), 32'h0);
    step();
    chk("t1_ready_clear", 32'(bus.ready), 32'h0);

    // Read slave0 with PREADY glitches in SETUP and on a non-selected lane.
    launch(1'b0, 32'h1000_0000, 32'hFFFF_FFFF, 1'b1, 32'hDEAD_BEEF, 1'b0, 6);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("t2_paddr_stable", bus.PADDR, 32'h1000_0000);
      chk("t2_psel", 32'(bus.PSEL), 32'h1);
      chk("t2_penable", 32'(bus.PENABLE), (i >= 2) ? 32'h1 : 32'h0);
      chk("t2_pwdata_kept", bus.PWDATA, 32'h0000_1234);
      if (i == 1) bus.PREADY = 4'b0101;
      if (i == 2) bus.PREADY = 4'b0100;
      if (i == 5) bus.PREADY = 4'b0001;
    end
    step();
    bus.PREADY = 4'b0000;
    chk("t2_psel_done", 32'(bus.PSEL), 32'h0);
    chk("t2_paddr_hold", bus.PADDR, 32'h1000_0000);
    step();
    chk("t2_rdata_hold", bus.rdata, 32'hDEAD_BEEF);

    // Unmapped addresses above, just past, and just below the window.
    for (int j = 0; j < 3; j++) begin
      launch(1'b0, unmapped_addrs[j], 32'h0, 1'b1, 32'h0, 1'b1, 2);
      step();
      chk("t3_psel", 32'(bus.PSEL), 32'h0);
      chk("t3_penable", 32'(bus.PENABLE), 32'h0);
      step();
      step();
    end

    // Slave3 never answers: abort after 16 ACCESS cycles.
    launch(1'b0, 32'h1000_3FFC, 32'h0, 1'b1, 32'h0, 1'b1, 18);
    for (int i = 1; i <= 17; i++) begin
      step();
      chk("t4_psel", 32'(bus.PSEL), 32'h8);
      chk("t4_penable", 32'(bus.PENABLE), (i >= 2) ? 32'h1 : 32'h0);
    end
    step();
    chk("t4_psel_drop", 32'(bus.PSEL), 32'h0);
    chk("t4_penable_drop", 32'(bus.PENABLE), 32'h0);
    step();

    // Back-to-back write then read on slave2 with transfer held high.
    bus.PRDATA = {32'h3333_3333, 32'h0BAD_F00D, 32'h1111_1111, 32'hDEAD_BEEF};
    launch(1'b1, 32'h1000_2008, 32'hA5A5_5A5A, 1'b1, 32'h0, 1'b0, 3);
    step();
    chk("t5a_psel", 32'(bus.PSEL), 32'h4);
    step();
    bus.PREADY = 4'b0100;
    step();
    bus.PREADY = 4'b0000;
    launch(1'b0, 32'h1000_2010, 32'h0, 1'b1, 32'h0BAD_F00D, 1'b0, 3);
    step();
    chk("t5b_psel_setup", 32'(bus.PSEL), 32'h4);
    chk("t5b_penable_setup", 32'(bus.PENABLE), 32'h0);
    chk("t5b_paddr", bus.PADDR, 32'h1000_2010);
    chk("t5b_pwrite", 32'(bus.PWRITE), 32'h0);
    chk("t5b_pwdata_kept", bus.PWDATA, 32'hA5A5_5A5A);
    step();
    bus.PREADY = 4'b0100;
    step();
    bus.PREADY = 4'b0000;
    step();

    // Reset in ACCESS: everything clears, no strobe, next transfer is normal.
    launch(1'b0, 32'h1000_1000, 32'h0, 1'b0, 32'h0, 1'b0, 0);
    step();
    step();
    chk("t6_in_access", 32'(bus.PENABLE), 32'h1);
    PRESET       = 1'b1;
    bus.transfer = 1'b0;
    step();
    chk_zero_outputs("t6_reset");
    PRESET = 1'b0;
    step();
    step();
    launch(1'b1, 32'h1000_0010, 32'h0000_CAFE, 1'b1, 32'h0, 1'b0, 4);
    step();
    chk("t6_psel", 32'(bus.PSEL), 32'h1);
    chk("t6_pwdata", bus.PWDATA, 32'h0000_CAFE);
    step();
    step();
    bus.PREADY = 4'b0001;
    step();
    bus.PREADY = 4'b0000;
    step();

    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
